// File: rtl/decode_out_buffer.sv
// decode_out_buffer: output FIFO between the decode control unit
// and the CPU fetch port, with single/double push and branch flush.
module decode_out_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     outBuff1,
  input  logic                     outBuff2,
  input  logic                     outMux,
  input  logic [WIDTH-1:0]         tableData,
  input  logic [WIDTH-1:0]         bypassData,
  input  logic                     flush,
  input  logic                     cpuReady,
  output logic [WIDTH-1:0]         instrOut,
  output logic                     instrValid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     strobeErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             pop;
  logic [1:0]       pushSize;
  logic [CW:0]      nextOcc;
  logic             fits;
  logic             accept;
  logic             reject;
  logic [WIDTH-1:0] firstWord;

  assign instrValid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign instrOut   = instrValid ? mem[rdPtr] : '0;
  assign pop        = instrValid & cpuReady;

  // outBuff2 dominates when both strobes are raised
  always_comb begin
    pushSize = 2'd0;
    if (outBuff2)
      pushSize = 2'd2;
    else if (outBuff1)
      pushSize = 2'd1;
  end

  assign firstWord = (outBuff2 || !outMux) ? tableData : bypassData;

  // a pop in the same cycle frees its slot for the push
  assign nextOcc = {1'b0, count}
                 - (CW+1)'(pop)
                 + (CW+1)'(pushSize);
  assign fits    = (nextOcc <= (CW+1)'(DEPTH));
  assign accept  = (pushSize != 2'd0) && fits && !flush;
  assign reject  = (pushSize != 2'd0) && !fits && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      strobeErr <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (outBuff1 && outBuff2)
        strobeErr <= 1'b1;
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        if (reject)
          overflow <= 1'b1;
        if (accept) begin
          mem[wrPtr] <= firstWord;
          if (pushSize == 2'd2)
            mem[wrPtr + AW'(1)] <= bypassData;
          wrPtr <= wrPtr + AW'(pushSize);
        end
        if (pop)
          rdPtr <= rdPtr + AW'(1);
        count <= count
               - CW'(pop)
               + (accept ? CW'(pushSize) : CW'(0));
      end
    end
  end

endmodule

// File: tb/tb_decode_out_buffer.sv
// Bench for decode_out_buffer: directed pushes feed an expected-word
// queue; a negedge monitor compares every word the CPU accepts.
module tb_decode_out_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             outBuff1;
  logic             outBuff2;
  logic             outMux;
  logic [WIDTH-1:0] tableData;
  logic [WIDTH-1:0] bypassData;
  logic             flush;
  logic             cpuReady;
  logic [WIDTH-1:0] instrOut;
  logic             instrValid;
  logic             full;
  logic [2:0]       count;
  logic             overflow;
  logic             strobeErr;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] expq [$];

  decode_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .outBuff1   (outBuff1),
    .outBuff2   (outBuff2),
    .outMux     (outMux),
    .tableData  (tableData),
    .bypassData (bypassData),
    .flush      (flush),
    .cpuReady   (cpuReady),
    .instrOut   (instrOut),
    .instrValid (instrValid),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .strobeErr  (strobeErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: a word leaves the DUT whenever valid & ready (no flush)
  always @(negedge clk) begin
    if (reset && instrValid && cpuReady && !flush) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL pop: got 0x%0h expected nothing", instrOut);
      end else begin
        logic [WIDTH-1:0] e;
        e = expq.pop_front();
        if (instrOut !== e) begin
          errors++;
          $display("FAIL pop: got 0x%0h expected 0x%0h", instrOut, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    outBuff1   = 1'b0;
    outBuff2   = 1'b0;
    outMux     = 1'b0;
    tableData  = '0;
    bypassData = '0;
    flush      = 1'b0;
    cpuReady   = 1'b0;
  endtask

  // apply one cycle of stimulus; queue expected words if accepted
  task automatic issue(input logic b1, input logic b2,
                       input logic mux,
                       input logic [31:0] t, input logic [31:0] b,
                       input logic rdy, input logic fl,
                       input logic acc);
    outBuff1   = b1;
    outBuff2   = b2;
    outMux     = mux;
    tableData  = t;
    bypassData = b;
    cpuReady   = rdy;
    flush      = fl;
    if (fl)
      expq.delete();
    if (acc) begin
      if (b2) begin
        expq.push_back(t);
        expq.push_back(b);
      end else begin
        expq.push_back(mux ? b : t);
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++)
      issue(1'b0, 1'b0, 1'b0, 0, 0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(instrValid), 0);
    chk("rst_out", instrOut, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_full", 32'(full), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b0, 3);
    chk("idle_count", 32'(count), 0);
    chk("idle_valid", 32'(instrValid), 0);
    chk("idle_out", instrOut, 0);

    issue(1'b1, 1'b0, 1'b0, 32'hA1, 32'hFFFF, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 1'b1, 32'hDEAD, 32'hB2, 1'b0, 1'b0, 1'b1);
    chk("single_count", 32'(count), 2);
    chk("single_head", instrOut, 32'hA1);
    idle(1'b1, 2);
    chk("single_drained", 32'(instrValid), 0);

    issue(1'b0, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
    chk("dbl_count", 32'(count), 4);
    chk("dbl_full", 32'(full), 1);
    idle(1'b1, 4);
    chk("dbl_drained", 32'(instrValid), 0);

    issue(1'b1, 1'b0, 1'b0, 32'h31, 0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 32'h32, 0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 1'b0, 32'h33, 0, 1'b0, 1'b0, 1'b1);
    chk("ovf_pre_count", 32'(count), 3);
    chk("ovf_pre_flag", 32'(overflow), 0);
    issue(1'b0, 1'b1, 1'b0, 32'h44, 32'h55, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 3);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", instrOut, 32'h31);
    idle(1'b0, 1);
    chk("ovf_sticky", 32'(overflow), 1);
    issue(1'b0, 1'b1, 1'b0, 32'h66, 32'h77, 1'b1, 1'b0, 1'b1);
    chk("dbl_pop_count", 32'(count), 4);
    chk("dbl_pop_full", 32'(full), 1);
    issue(1'b1, 1'b0, 1'b0, 32'h88, 0, 1'b1, 1'b0, 1'b1);
    chk("full_pop_count", 32'(count), 4);
    idle(1'b1, 1);
    chk("pre_flush_count", 32'(count), 3);

    issue(1'b1, 1'b0, 1'b0, 32'h99, 0, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(instrValid), 0);
    chk("flush_out", instrOut, 0);
    chk("flush_ovf", 32'(overflow), 1);

    for (int i = 1; i <= 10; i++) begin
      issue(1'b1, 1'b0, 1'b0, 32'(i), 0, 1'b1, 1'b0, 1'b1);
      chk("wrap_count", 32'(count), 1);
    end
    idle(1'b1, 1);
    chk("wrap_drained", 32'(instrValid), 0);
    chk("wrap_queue", 32'(expq.size()), 0);

    issue(1'b1, 1'b1, 1'b1, 32'hC1, 32'hC2, 1'b0, 1'b0, 1'b1);
    chk("strb_count", 32'(count), 2);
    chk("strb_flag", 32'(strobeErr), 1);
    chk("strb_head", instrOut, 32'hC1);
    issue(1'b1, 1'b0, 1'b0, 32'hD1, 0, 1'b0, 1'b0, 1'b1);
    chk("mid_count", 32'(count), 3);

    #2;
    reset = 1'b0;
    expq.delete();
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(instrValid), 0);
    chk("arst_out", instrOut, 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_strb", 32'(strobeErr), 0);
    chk("arst_full", 32'(full), 0);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
